// File: rtl/mem_rd_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rd_arbiter
//   Shares one variable-latency memory read port between the instruction fetch
//   port (port 0) and the data port (port 1). Each port owns a one-deep pending
//   slot. Data has priority, but an instruction request that keeps losing is
//   forced through after STARVE_MAX consecutive data grants. Only one memory
//   read is ever outstanding, and each response is routed back to the port
//   that issued it.
//
//   Optional feature macro: MEM_TIMEOUT_EN
//     defined   -> WAIT watchdog; after TIMEOUT cycles without mem_ready the
//                  owner receives a response with all-ones data and the
//                  internal sticky flag tmo_r is set.
//     undefined -> the arbiter waits for mem_ready indefinitely.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   re0/raddr0, busy0          instruction request strobe/address, slot full
//   re1/raddr1, busy1          data request strobe/address, slot full
//   mem_re/mem_raddr           memory read strobe (1 cycle per grant)/address
//   mem_ready/mem_rdata        memory response pulse/data
//   iready/iraddr_out/idata    instruction response pulse/address/data
//   dready/draddr_out/ddata    data response pulse/address/data
//   ovf                        sticky: a strobe arrived while its slot was full
// -----------------------------------------------------------------------------
module mem_rd_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          re0,
    input  logic [AW-1:0] raddr0,
    output logic          busy0,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic          busy1,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          iready,
    output logic [AW-1:0] iraddr_out,
    output logic [DW-1:0] idata,
    output logic          dready,
    output logic [AW-1:0] draddr_out,
    output logic [DW-1:0] ddata,
    output logic          ovf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int             CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);

    // Reject configurations the starvation counter and watchdog cannot honour.
    if (STARVE_MAX < 1) begin : g_bad_starve
        $error("mem_rd_arbiter: STARVE_MAX must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_rd_arbiter: TIMEOUT must be >= 1");
    end

    logic [1:0]    state_r;
    logic [AW-1:0] slot0_addr_r;
    logic [AW-1:0] slot1_addr_r;
    logic          owner_r;        // 0 = instruction, 1 = data
    logic [CW-1:0] starve_cnt_r;

    logic          gnt_data_s;
    logic          gnt_instr_s;
    logic          take0_s;
    logic          take1_s;
    logic          resp_s;
    logic          tmo_hit_s;
    logic [DW-1:0] resp_data_s;

    // Grant, capture and response decisions for the current cycle.
    always_comb begin
        // Data wins a tie unless the instruction port has lost STARVE_MAX times in a row.
        gnt_data_s  = (state_r == ST_IDLE) && busy1 &&
                      !(busy0 && (starve_cnt_r == STARVE_LIM));
        gnt_instr_s = (state_r == ST_IDLE) && busy0 && !gnt_data_s;
        // A slot emptied by this edge's grant can accept a new request on the same edge.
        take0_s     = re0 && (!busy0 || gnt_instr_s);
        take1_s     = re1 && (!busy1 || gnt_data_s);
        resp_s      = (state_r == ST_WAIT) && (mem_ready || tmo_hit_s);
        resp_data_s = mem_ready ? mem_rdata : {DW{1'b1}};
    end

`ifdef MEM_TIMEOUT_EN
    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    logic [TW-1:0] wait_cnt_r;
    logic          tmo_r;

    // Watchdog fires on the TIMEOUT-th WAIT cycle that sees no mem_ready.
    always_comb begin
        tmo_hit_s = !mem_ready && (wait_cnt_r == TLIM);
    end

    // WAIT-cycle counter (cleared outside WAIT) and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {TW{1'b0}};
            tmo_r      <= 1'b0;
        end else begin
            if (state_r == ST_WAIT && !resp_s) begin
                wait_cnt_r <= wait_cnt_r + {{(TW-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_r <= {TW{1'b0}};
            end
            if (state_r == ST_WAIT && tmo_hit_s) begin
                tmo_r <= 1'b1;
            end
        end
    end
`else
    // No watchdog: WAIT ends only on mem_ready.
    always_comb begin
        tmo_hit_s = 1'b0;
    end
`endif

    // Pending slots and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy0        <= 1'b0;
            busy1        <= 1'b0;
            slot0_addr_r <= {AW{1'b0}};
            slot1_addr_r <= {AW{1'b0}};
            ovf          <= 1'b0;
        end else begin
            if (take0_s) begin
                busy0        <= 1'b1;
                slot0_addr_r <= raddr0;
            end else if (gnt_instr_s) begin
                busy0 <= 1'b0;
            end
            if (take1_s) begin
                busy1        <= 1'b1;
                slot1_addr_r <= raddr1;
            end else if (gnt_data_s) begin
                busy1 <= 1'b0;
            end
            if ((re0 && !take0_s) || (re1 && !take1_s)) begin
                ovf <= 1'b1;
            end
        end
    end

    // Consecutive data grants that bypassed a waiting instruction request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {CW{1'b0}};
        end else if (gnt_instr_s) begin
            starve_cnt_r <= {CW{1'b0}};
        end else if (gnt_data_s && busy0 && (starve_cnt_r != STARVE_LIM)) begin
            starve_cnt_r <= starve_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // IDLE/ISSUE/WAIT sequencer driving the memory read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mem_re    <= 1'b0;
            mem_raddr <= {AW{1'b0}};
            owner_r   <= 1'b0;
        end else begin
            mem_re <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_data_s || gnt_instr_s) begin
                        mem_re    <= 1'b1;
                        mem_raddr <= gnt_data_s ? slot1_addr_r : slot0_addr_r;
                        owner_r   <= gnt_data_s;
                        state_r   <= ST_ISSUE;
                    end
                end
                // A response in the strobe cycle cannot belong to this request.
                ST_ISSUE: state_r <= ST_WAIT;
                ST_WAIT: begin
                    if (resp_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Response routing: pulse and hold address/data for the owning port only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iready     <= 1'b0;
            dready     <= 1'b0;
            iraddr_out <= {AW{1'b0}};
            draddr_out <= {AW{1'b0}};
            idata      <= {DW{1'b0}};
            ddata      <= {DW{1'b0}};
        end else begin
            iready <= resp_s && !owner_r;
            dready <= resp_s && owner_r;
            if (resp_s && !owner_r) begin
                iraddr_out <= mem_raddr;
                idata      <= resp_data_s;
            end
            if (resp_s && owner_r) begin
                draddr_out <= mem_raddr;
                ddata      <= resp_data_s;
            end
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_rd_arbiter
//   Directed bench for mem_rd_arbiter (STARVE_MAX=4, TIMEOUT=8). The memory is
//   played by the stimulus sequence itself; every expected value is written
//   out by hand. The timeout scenario is compiled only with MEM_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_mem_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        re0, re1;
    logic [15:0] raddr0, raddr1;
    logic        busy0, busy1;
    logic        mem_re;
    logic [15:0] mem_raddr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        iready, dready;
    logic [15:0] iraddr_out, draddr_out, idata, ddata;
    logic        ovf;

    int passed = 0;
    int total  = 0;
    int mem_re_cnt = 0;
    int base_cnt;

    mem_rd_arbiter #(.AW(16), .DW(16), .STARVE_MAX(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .re0(re0), .raddr0(raddr0), .busy0(busy0),
        .re1(re1), .raddr1(raddr1), .busy1(busy1),
        .mem_re(mem_re), .mem_raddr(mem_raddr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .iready(iready), .iraddr_out(iraddr_out), .idata(idata),
        .dready(dready), .draddr_out(draddr_out), .ddata(ddata),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Count every cycle in which the memory strobe is high.
    always @(posedge clk) begin
        if (mem_re === 1'b1) mem_re_cnt <= mem_re_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Wait (bounded) for the next grant and check its address.
    task automatic wait_grant(input string tag, input logic [15:0] exp_addr);
        int n = 0;
        while (mem_re !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".grant"}, {31'd0, mem_re}, 32'd1);
        chk({tag, ".addr"}, {16'd0, mem_raddr}, {16'd0, exp_addr});
    endtask

    // Serve one grant: optional data-slot refill, lat WAIT cycles, then respond.
    task automatic serve(input string tag, input logic [15:0] exp_addr, input bit exp_port,
                         input logic [15:0] data, input int lat,
                         input bit refill, input logic [15:0] refill_addr);
        wait_grant(tag, exp_addr);
        if (refill) begin
            re1    = 1'b1;
            raddr1 = refill_addr;
        end
        tick();
        re1 = 1'b0;
        chk({tag, ".re_one_cycle"}, {31'd0, mem_re}, 32'd0);
        repeat (lat) tick();
        chk({tag, ".no_early_resp"}, {30'd0, iready, dready}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = data;
        tick();
        mem_ready = 1'b0;
        chk({tag, ".ready"}, {30'd0, iready, dready}, exp_port ? 32'd1 : 32'd2);
        if (exp_port) begin
            chk({tag, ".draddr"}, {16'd0, draddr_out}, {16'd0, exp_addr});
            chk({tag, ".ddata"}, {16'd0, ddata}, {16'd0, data});
        end else begin
            chk({tag, ".iraddr"}, {16'd0, iraddr_out}, {16'd0, exp_addr});
            chk({tag, ".idata"}, {16'd0, idata}, {16'd0, data});
        end
        tick();
        chk({tag, ".pulse_end"}, {30'd0, iready, dready}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; re0 = 1'b0; re1 = 1'b0; raddr0 = 16'h0; raddr1 = 16'h0;
        mem_ready = 1'b0; mem_rdata = 16'h0;
        repeat (3) tick();
        chk("rst.mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst.busy", {30'd0, busy0, busy1}, 32'd0);
        chk("rst.ovf", {31'd0, ovf}, 32'd0);
        chk("rst.ready", {30'd0, iready, dready}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single data read, memory answers after a few cycles.
        re1 = 1'b1; raddr1 = 16'h0040;
        tick();
        re1 = 1'b0;
        chk("t1.busy1", {31'd0, busy1}, 32'd1);
        chk("t1.no_re_yet", {31'd0, mem_re}, 32'd0);
        base_cnt = mem_re_cnt;
        serve("t1", 16'h0040, 1'b1, 16'hBEEF, 2, 1'b0, 16'h0);
        chk("t1.one_mem_re", mem_re_cnt - base_cnt, 32'd1);
        chk("t1.idata_untouched", {16'd0, idata}, 32'd0);

        // 2: simultaneous requests, data first then instruction.
        re0 = 1'b1; raddr0 = 16'h0100; re1 = 1'b1; raddr1 = 16'h0200;
        tick();
        re0 = 1'b0; re1 = 1'b0;
        serve("t2.d", 16'h0200, 1'b1, 16'h2222, 1, 1'b0, 16'h0);
        serve("t2.i", 16'h0100, 1'b0, 16'h1111, 1, 1'b0, 16'h0);
        chk("t2.ddata_held", {16'd0, ddata}, 32'h2222);

        // 3: instruction pending, data slot refilled on every grant.
        re0 = 1'b1; raddr0 = 16'h0300; re1 = 1'b1; raddr1 = 16'h0400;
        tick();
        re0 = 1'b0; re1 = 1'b0;
        serve("t3.d0", 16'h0400, 1'b1, 16'h4000, 0, 1'b1, 16'h0401);
        chk("t3.instr_waiting", {31'd0, busy0}, 32'd1);
        serve("t3.d1", 16'h0401, 1'b1, 16'h4001, 0, 1'b1, 16'h0402);
        serve("t3.d2", 16'h0402, 1'b1, 16'h4002, 0, 1'b1, 16'h0403);
        serve("t3.d3", 16'h0403, 1'b1, 16'h4003, 0, 1'b1, 16'h0404);
        serve("t3.i", 16'h0300, 1'b0, 16'h3333, 0, 1'b0, 16'h0);
        chk("t3.cnt_cleared", {29'd0, dut.starve_cnt_r}, 32'd0);
        serve("t3.d4", 16'h0404, 1'b1, 16'h4004, 0, 1'b0, 16'h0);
        chk("t3.ovf_clear", {31'd0, ovf}, 32'd0);

        // 4: second data strobe while the data slot is still full is dropped.
        base_cnt = mem_re_cnt;
        re0 = 1'b1; raddr0 = 16'h0800;
        tick();
        re0 = 1'b0;
        wait_grant("t4.i", 16'h0800);
        re1 = 1'b1; raddr1 = 16'h0900;
        tick();
        raddr1 = 16'h0901;
        tick();
        re1 = 1'b0;
        chk("t4.busy1", {31'd0, busy1}, 32'd1);
        chk("t4.ovf", {31'd0, ovf}, 32'd1);
        mem_ready = 1'b1; mem_rdata = 16'h8888;
        tick();
        mem_ready = 1'b0;
        chk("t4.iready", {30'd0, iready, dready}, 32'd2);
        serve("t4.d", 16'h0900, 1'b1, 16'h9999, 1, 1'b0, 16'h0);
        repeat (10) tick();
        chk("t4.two_grants", mem_re_cnt - base_cnt, 32'd2);

        // 5: reset in WAIT, late mem_ready must be ignored.
        re0 = 1'b1; raddr0 = 16'h0A00;
        tick();
        re0 = 1'b0;
        wait_grant("t5.i", 16'h0A00);
        tick();
        rst_n = 1'b0;
        tick();
        chk("t5.rst_mem", {15'd0, mem_re, mem_raddr}, 32'd0);
        chk("t5.rst_flags", {28'd0, busy0, busy1, ovf, iready}, 32'd0);
        chk("t5.rst_iout", {iraddr_out, idata}, 32'd0);
        chk("t5.rst_dout", {draddr_out, ddata}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        mem_ready = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_ready = 1'b0;
        chk("t5.stale_ignored", {29'd0, iready, dready, mem_re}, 32'd0);
        tick();
        chk("t5.still_quiet", {29'd0, iready, dready, mem_re}, 32'd0);
        re0 = 1'b1; raddr0 = 16'h0B00;
        tick();
        re0 = 1'b0;
        serve("t5.i2", 16'h0B00, 1'b0, 16'h0B0B, 1, 1'b0, 16'h0);

`ifdef MEM_TIMEOUT_EN
        // 6: memory never answers; watchdog returns all-ones after 8 WAIT cycles.
        begin
            int n = 0;
            re1 = 1'b1; raddr1 = 16'h0700;
            tick();
            re1 = 1'b0;
            wait_grant("t6.d", 16'h0700);
            while (dready !== 1'b1 && n < 30) begin
                tick();
                n++;
            end
            chk("t6.latency", n, 32'd9);
            chk("t6.ddata", {16'd0, ddata}, 32'hFFFF);
            chk("t6.draddr", {16'd0, draddr_out}, 32'h0700);
            chk("t6.tmo", {31'd0, dut.tmo_r}, 32'd1);
            chk("t6.idle", {30'd0, dut.state_r}, 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
